// File: rtl/lcd_stream_ctrl.sv
// HD44780-style 4-bit character LCD controller with write FIFO,
// power-on init sequence, programmable nibble timing and line wrap.
module lcd_stream_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int T_POWERUP  = 750000,
    parameter int T_INIT0    = 205000,
    parameter int T_INIT1    = 5000,
    parameter int T_CMD      = 2000,
    parameter int T_CLEAR    = 82000,
    parameter int T_SETUP    = 2,
    parameter int T_PULSE    = 12,
    parameter int T_GAP      = 50,
    parameter int COLS       = 16,
    parameter int AUTO_WRAP  = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iValid,
    input  logic [7:0] iData,
    input  logic       iIsCmd,
    output logic       oReady,
    output logic       oLCD_Enabled,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data,
    output logic       oIsInitialized,
    output logic       oBusy,
    output logic       oOverflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] LP_POWERUP = 32'(T_POWERUP - 1);
    localparam logic [31:0] LP_INIT0   = 32'(T_INIT0 - 1);
    localparam logic [31:0] LP_INIT1   = 32'(T_INIT1 - 1);
    localparam logic [31:0] LP_CMD     = 32'(T_CMD - 1);
    localparam logic [31:0] LP_CLEAR   = 32'(T_CLEAR - 1);
    localparam logic [31:0] LP_SETUP   = 32'(T_SETUP - 1);
    localparam logic [31:0] LP_PULSE   = 32'(T_PULSE - 1);
    localparam logic [31:0] LP_GAP     = 32'(T_GAP - 1);
    localparam logic [7:0]  COL_LAST   = 8'(COLS - 1);
    localparam logic [7:0]  COL_MAX    = 8'(COLS);

    typedef enum logic [2:0] {
        S_POWERUP, S_SETUP, S_PULSE, S_HOLD, S_GAP, S_WAIT, S_IDLE
    } state_t;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    state_t      state;
    logic [31:0] timer;
    logic [31:0] wait_len;
    logic [2:0]  init_step;
    logic [3:0]  cur_lsn;
    logic        cur_rs;
    logic        single;
    logic        lsn;
    logic [7:0]  column;
    logic        line;
    logic        wrap_pend;

    logic        tdone;
    logic [2:0]  nstep;
    logic [7:0]  ibyte;
    logic        go;
    logic [7:0]  d_byte;
    logic        d_rs;
    logic        d_single;
    logic [31:0] d_wait;

    assign oReady = (count != (AW+1)'(FIFO_DEPTH));
    assign push = iValid && oReady;
    assign oLCD_RW = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oBusy = (state != S_IDLE) || (count != '0) || wrap_pend;

    // End-of-interval detect for the current state's timer
    always_comb begin
        tdone = 1'b0;
        case (state)
            S_POWERUP: tdone = (timer == LP_POWERUP);
            S_SETUP:   tdone = (timer == LP_SETUP);
            S_PULSE:   tdone = (timer == LP_PULSE);
            S_HOLD:    tdone = 1'b1;
            S_GAP:     tdone = (timer == LP_GAP);
            S_WAIT:    tdone = (timer == wait_len);
            default:   tdone = 1'b0;
        endcase
    end

    // Choose the next item to launch: init step, wrap command or FIFO head
    always_comb begin
        nstep = (state == S_POWERUP) ? 3'd0 : init_step + 3'd1;
        case (nstep)
            3'd0, 3'd1, 3'd2: ibyte = 8'h30;
            3'd3:    ibyte = 8'h20;
            3'd4:    ibyte = 8'h28;
            3'd5:    ibyte = 8'h06;
            3'd6:    ibyte = 8'h0C;
            default: ibyte = 8'h01;
        endcase
        d_byte   = ibyte;
        d_rs     = 1'b0;
        d_single = 1'b0;
        if (!oIsInitialized) begin
            d_single = (nstep < 3'd4);
        end else if (wrap_pend) begin
            d_byte = line ? 8'h80 : 8'hC0;
        end else begin
            d_byte = mem[rd_ptr][7:0];
            d_rs   = !mem[rd_ptr][8];
        end
        if (d_single)
            d_wait = (nstep == 3'd0) ? LP_INIT0 :
                     (nstep == 3'd1) ? LP_INIT1 : LP_CMD;
        else if (!d_rs && (d_byte == 8'h01 || d_byte == 8'h02))
            d_wait = LP_CLEAR;
        else
            d_wait = LP_CMD;
        go = (state == S_POWERUP && tdone)
          || (state == S_WAIT && tdone && !oIsInitialized
              && init_step != 3'd7)
          || ((state == S_IDLE || (state == S_WAIT && tdone))
              && oIsInitialized && (wrap_pend || count != '0));
        pop = go && oIsInitialized && !wrap_pend;
    end

    // FIFO storage write
    always_ff @(posedge Clock) begin
        if (push)
            mem[wr_ptr] <= {iIsCmd, iData};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Sticky overflow flag for writes attempted while full
    always_ff @(posedge Clock) begin
        if (Reset)
            oOverflow <= 1'b0;
        else if (iValid && !oReady)
            oOverflow <= 1'b1;
    end

    // Main sequencer: init, nibble strobes, gaps, waits, position tracking
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= S_POWERUP;
            timer          <= '0;
            wait_len       <= '0;
            init_step      <= '0;
            cur_lsn        <= '0;
            cur_rs         <= 1'b0;
            single         <= 1'b0;
            lsn            <= 1'b0;
            column         <= '0;
            line           <= 1'b0;
            wrap_pend      <= 1'b0;
            oLCD_Enabled   <= 1'b0;
            oLCD_RS        <= 1'b0;
            oLCD_Data      <= '0;
            oIsInitialized <= 1'b0;
        end else if (go) begin
            state     <= S_SETUP;
            timer     <= '0;
            wait_len  <= d_wait;
            cur_lsn   <= d_byte[3:0];
            cur_rs    <= d_rs;
            single    <= d_single;
            lsn       <= 1'b0;
            oLCD_RS   <= d_rs;
            oLCD_Data <= d_byte[7:4];
            if (!oIsInitialized) begin
                init_step <= nstep;
            end else if (wrap_pend) begin
                wrap_pend <= 1'b0;
                line      <= !line;
                column    <= '0;
            end else if (d_rs) begin
                column <= column + 8'd1;
                if (AUTO_WRAP != 0 && column == COL_LAST)
                    wrap_pend <= 1'b1;
            end else if (d_byte == 8'h01 || d_byte == 8'h02) begin
                column <= '0;
                line   <= 1'b0;
            end else if (d_byte[7]) begin
                line   <= d_byte[6];
                column <= ({2'b00, d_byte[5:0]} > COL_MAX) ?
                          COL_MAX : {2'b00, d_byte[5:0]};
            end
        end else begin
            timer <= timer + 32'd1;
            case (state)
                S_SETUP: if (tdone) begin
                    state        <= S_PULSE;
                    timer        <= '0;
                    oLCD_Enabled <= 1'b1;
                end
                S_PULSE: if (tdone) begin
                    state        <= S_HOLD;
                    timer        <= '0;
                    oLCD_Enabled <= 1'b0;
                end
                S_HOLD: begin
                    timer     <= '0;
                    oLCD_RS   <= 1'b0;
                    oLCD_Data <= '0;
                    state     <= (single || lsn) ? S_WAIT : S_GAP;
                end
                S_GAP: if (tdone) begin
                    state     <= S_SETUP;
                    timer     <= '0;
                    lsn       <= 1'b1;
                    oLCD_RS   <= cur_rs;
                    oLCD_Data <= cur_lsn;
                end
                S_WAIT: if (tdone) begin
                    state          <= S_IDLE;
                    timer          <= '0;
                    oIsInitialized <= 1'b1;
                end
                S_IDLE: timer <= '0;
                default: ;
            endcase
        end
    end

endmodule
